rand_key_gen: RTL

//  Parametrised pseudo-random key selector for the game logic.

---
 rtl/rand_key_gen_if.sv | 22 ++
 rtl/rand_key_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rand_key_gen_if.sv
// Control and result bundle between the game control FSM and the random key selector.
interface rand_key_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             req;
  logic             seed_load;
  logic [15:0]      seed_in;
  logic [WIDTH-1:0] key;
  logic             key_valid;
  logic             busy;

  modport master (
    output en, req, seed_load, seed_in,
    input  key, key_valid, busy
  );

  modport slave (
    input  en, req, seed_load, seed_in,
    output key, key_valid, busy
  );
endinterface

// File: rtl/rand_key_gen.sv
// Pseudo-random key index selector fed by a free-running 16-bit Galois LFSR, with
// on-demand and periodic draws, reseeding and optional no-repeat rejection.
module rand_key_gen #(
  parameter int          WIDTH       = 4,
  parameter int          NUM_KEYS    = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          NO_REPEAT   = 1,
  parameter int          MAX_TRIES   = 8,
  parameter int          AUTO_PERIOD = 4000000
) (
  input logic           clk,
  input logic           rst_n,
  rand_key_gen_if.slave bus
);

  localparam logic [15:0]      POLY         = 16'hB400;
  localparam int               TCW          = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TCW-1:0]   TRY_LAST     = TCW'(MAX_TRIES - 1);
  localparam logic [WIDTH:0]   NUM_KEYS_W   = (WIDTH + 1)'(NUM_KEYS);
  localparam logic [WIDTH-1:0] LAST_KEY     = WIDTH'(NUM_KEYS - 1);
  localparam bit               ALLOW_REPEAT = (NO_REPEAT == 0) || (NUM_KEYS == 1);

  typedef enum logic {
    IDLE,
    DRAW
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d, lfsr_step;
  logic [TCW-1:0]   tries_q, tries_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             valid_q, valid_d;
  logic             auto_req;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] key_next;
  logic             cand_ok;

  // The LFSR free-runs every cycle; a reseed wins over the shift and zero is never kept.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);
    lfsr_d    = bus.seed_load ? bus.seed_in : lfsr_step;
    if (lfsr_d == 16'h0000) begin
      lfsr_d = SEED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int             TMW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [TMW-1:0] TIMER_LAST = TMW'(AUTO_PERIOD - 1);

      logic [TMW-1:0] timer_q, timer_d;

      assign auto_req = bus.en && (timer_q == TIMER_LAST);

      always_comb begin
        timer_d = timer_q + TMW'(1);
        if (!bus.en || auto_req) begin
          timer_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end
    end else begin : g_no_auto
      assign auto_req = 1'b0;
    end
  endgenerate

  // The low LFSR bits are the candidate; out-of-range or repeated values are retried.
  assign cand     = lfsr_q[WIDTH-1:0];
  assign key_next = (key_q == LAST_KEY) ? '0 : key_q + WIDTH'(1);
  assign cand_ok  = ({1'b0, cand} < NUM_KEYS_W) && (ALLOW_REPEAT || (cand != key_q));

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    key_d   = key_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req || auto_req)) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          key_d   = cand;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (tries_q == TRY_LAST) begin
          key_d   = key_next;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          tries_d = tries_q + TCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tries_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.busy      = (state_q == DRAW);

endmodule
